gray_counter: RTL and testbench

Parametrised up/down counter that keeps a binary count and its reflected-binary Gray code as registered outputs. It replaces fixed 4-bit binary-to-Gray lookup logic wherever a Gray-coded sequence must be produced over time, for example for LED demo patterns or pointers crossing into another clock domain. Outputs carry load, wrap and saturate behaviour and always change by exactly one Gray bit per count step.

---
 rtl/gray_counter_if.sv | 23 ++
 rtl/gray_counter.sv | 61 ++++++
 tb/tb_gray_counter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/gray_counter_if.sv
// Control/status bundle for gray_counter: step and load controls in, count state out.
interface gray_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] gray;
  logic             wrap;
  logic             at_limit;

  modport master (
    output en, up, load, load_bin,
    input  bin, gray, wrap, at_limit
  );

  modport slave (
    input  en, up, load, load_bin,
    output bin, gray, wrap, at_limit
  );
endinterface

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered reflected-binary Gray copy,
// optional saturation at the range ends and a one-cycle wrap pulse.
module gray_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter bit          SATURATE = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  gray_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MaxVal = '1;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (bus.load) begin
      cnt_d = bus.load_bin;
    end else if (bus.en) begin
      if (bus.up) begin
        if (cnt_q != MaxVal) begin
          cnt_d = cnt_q + WIDTH'(1);
        end else if (!SATURATE) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end
      end else begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - WIDTH'(1);
        end else if (!SATURATE) begin
          cnt_d  = MaxVal;
          wrap_d = 1'b1;
        end
      end
    end
    // Gray is registered from the next binary value so both outputs move together.
    g_d = cnt_d ^ (cnt_d >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      g_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      g_q    <= g_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.bin      = cnt_q;
  assign bus.gray     = g_q;
  assign bus.wrap     = wrap_q;
  assign bus.at_limit = bus.up ? (cnt_q == MaxVal) : (cnt_q == '0);

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter: four instances cover wrap, saturate, WIDTH=8 and WIDTH=2.
module tb_gray_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  gray_counter_if #(.WIDTH(4)) ia ();
  gray_counter_if #(.WIDTH(4)) ib ();
  gray_counter_if #(.WIDTH(8)) ic ();
  gray_counter_if #(.WIDTH(2)) id ();

  gray_counter #(.WIDTH(4), .SATURATE(1'b0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  gray_counter #(.WIDTH(4), .SATURATE(1'b1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  gray_counter #(.WIDTH(8), .SATURATE(1'b0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));
  gray_counter #(.WIDTH(2), .SATURATE(1'b0)) dut_d (.clk(clk), .rst_n(rst_n), .bus(id));

  logic [3:0] sweep_gray [17] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                  4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                  4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
  logic [1:0] w2_gray [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ia.en = 0; ia.up = 1; ia.load = 0; ia.load_bin = '0;
    ib.en = 0; ib.up = 0; ib.load = 0; ib.load_bin = '0;
    ic.en = 0; ic.up = 0; ic.load = 0; ic.load_bin = '0;
    id.en = 0; id.up = 0; id.load = 0; id.load_bin = '0;
    rst_n = 1'b0;
    #12;
    n_cmp++; if (ia.bin !== 4'd0) begin n_err++; $display("FAIL reset_bin got %0d want 0", ia.bin); end
    n_cmp++; if (ia.gray !== 4'd0) begin n_err++; $display("FAIL reset_gray got %b want 0000", ia.gray); end
    n_cmp++; if (ia.wrap !== 1'b0) begin n_err++; $display("FAIL reset_wrap got %b want 0", ia.wrap); end
    n_cmp++; if (ia.at_limit !== 1'b0) begin n_err++; $display("FAIL reset_at_limit_up got %b want 0", ia.at_limit); end
    n_cmp++; if (ib.at_limit !== 1'b1) begin n_err++; $display("FAIL reset_at_limit_dn got %b want 1", ib.at_limit); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_up_sweep();
    ia.en = 1; ia.up = 1;
    for (int k = 0; k < 17; k++) begin
      if (k > 0) tick();
      n_cmp++;
      if (ia.gray !== sweep_gray[k]) begin
        n_err++; $display("FAIL sweep_gray[%0d] got %b want %b", k, ia.gray, sweep_gray[k]);
      end
      n_cmp++;
      if (ia.bin !== 4'(k)) begin
        n_err++; $display("FAIL sweep_bin[%0d] got %0d want %0d", k, ia.bin, 4'(k));
      end
      n_cmp++;
      if (ia.wrap !== (k == 16)) begin
        n_err++; $display("FAIL sweep_wrap[%0d] got %b want %b", k, ia.wrap, k == 16);
      end
      n_cmp++;
      if (ia.at_limit !== (k == 15)) begin
        n_err++; $display("FAIL sweep_at_limit[%0d] got %b want %b", k, ia.at_limit, k == 15);
      end
    end
    ia.en = 0;
  endtask

  task automatic test_down_wrap();
    ia.up = 0; ia.en = 1;
    tick();
    n_cmp++; if (ia.bin !== 4'd15) begin n_err++; $display("FAIL down_wrap_bin got %0d want 15", ia.bin); end
    n_cmp++; if (ia.gray !== 4'b1000) begin n_err++; $display("FAIL down_wrap_gray got %b want 1000", ia.gray); end
    n_cmp++; if (ia.wrap !== 1'b1) begin n_err++; $display("FAIL down_wrap_pulse got %b want 1", ia.wrap); end
    tick();
    n_cmp++; if (ia.wrap !== 1'b0) begin n_err++; $display("FAIL down_wrap_clear got %b want 0", ia.wrap); end
    tick();
    tick();
    ia.en = 0;
    n_cmp++; if (ia.bin !== 4'd12) begin n_err++; $display("FAIL down_bin got %0d want 12", ia.bin); end
    n_cmp++; if (ia.gray !== 4'b1010) begin n_err++; $display("FAIL down_gray got %b want 1010", ia.gray); end
    n_cmp++; if (ia.wrap !== 1'b0) begin n_err++; $display("FAIL down_wrap_low got %b want 0", ia.wrap); end
  endtask

  task automatic test_load_priority();
    ia.load = 1; ia.load_bin = 4'd9; ia.en = 1; ia.up = 1;
    tick();
    ia.load = 0;
    n_cmp++; if (ia.bin !== 4'd9) begin n_err++; $display("FAIL load_bin got %0d want 9", ia.bin); end
    n_cmp++; if (ia.gray !== 4'b1101) begin n_err++; $display("FAIL load_gray got %b want 1101", ia.gray); end
    n_cmp++; if (ia.wrap !== 1'b0) begin n_err++; $display("FAIL load_wrap got %b want 0", ia.wrap); end
    tick();
    ia.en = 0;
    n_cmp++; if (ia.bin !== 4'd10) begin n_err++; $display("FAIL load_step_bin got %0d want 10", ia.bin); end
    n_cmp++; if (ia.gray !== 4'b1111) begin n_err++; $display("FAIL load_step_gray got %b want 1111", ia.gray); end
  endtask

  task automatic test_saturate();
    ib.load = 1; ib.load_bin = 4'd14;
    tick();
    ib.load = 0; ib.up = 1; ib.en = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (ib.bin !== 4'd15) begin n_err++; $display("FAIL sat_bin[%0d] got %0d want 15", k, ib.bin); end
      n_cmp++; if (ib.gray !== 4'b1000) begin n_err++; $display("FAIL sat_gray[%0d] got %b want 1000", k, ib.gray); end
      n_cmp++; if (ib.wrap !== 1'b0) begin n_err++; $display("FAIL sat_wrap[%0d] got %b want 0", k, ib.wrap); end
      n_cmp++; if (ib.at_limit !== 1'b1) begin n_err++; $display("FAIL sat_at_limit[%0d] got %b want 1", k, ib.at_limit); end
    end
    ib.up = 0;
    tick();
    ib.en = 0;
    n_cmp++; if (ib.bin !== 4'd14) begin n_err++; $display("FAIL sat_reverse_bin got %0d want 14", ib.bin); end
    n_cmp++; if (ib.gray !== 4'b1001) begin n_err++; $display("FAIL sat_reverse_gray got %b want 1001", ib.gray); end
  endtask

  task automatic test_async_reset();
    ia.load = 1; ia.load_bin = 4'd6;
    tick();
    ia.load = 0; ia.en = 1; ia.up = 1;
    n_cmp++; if (ia.bin !== 4'd6) begin n_err++; $display("FAIL arst_pre_bin got %0d want 6", ia.bin); end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (ia.bin !== 4'd0) begin n_err++; $display("FAIL arst_bin got %0d want 0", ia.bin); end
    n_cmp++; if (ia.gray !== 4'd0) begin n_err++; $display("FAIL arst_gray got %b want 0000", ia.gray); end
    n_cmp++; if (ia.wrap !== 1'b0) begin n_err++; $display("FAIL arst_wrap got %b want 0", ia.wrap); end
    tick();
    n_cmp++; if (ia.bin !== 4'd0) begin n_err++; $display("FAIL arst_hold_bin got %0d want 0", ia.bin); end
    rst_n = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      tick();
      n_cmp++; if (ia.bin !== 4'(k)) begin n_err++; $display("FAIL arst_resume_bin[%0d] got %0d want %0d", k, ia.bin, k); end
    end
    ia.en = 0;
  endtask

  task automatic test_width2_sweep();
    id.en = 1; id.up = 1;
    n_cmp++; if (id.gray !== 2'b00) begin n_err++; $display("FAIL w2_gray_init got %b want 00", id.gray); end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if (id.gray !== w2_gray[k]) begin n_err++; $display("FAIL w2_gray[%0d] got %b want %b", k, id.gray, w2_gray[k]); end
      n_cmp++; if (id.wrap !== (k == 3)) begin n_err++; $display("FAIL w2_wrap[%0d] got %b want %b", k, id.wrap, k == 3); end
    end
    id.en = 0;
  endtask

  task automatic test_random_w8();
    logic [7:0] m_bin;
    logic [7:0] m_gray;
    logic [7:0] prev_gray;
    logic       m_wrap;
    m_bin = ic.bin;
    for (int k = 0; k < 10000; k++) begin
      ic.en = 1'($urandom_range(0, 1));
      ic.up = 1'($urandom_range(0, 1));
      prev_gray = ic.gray;
      m_wrap = 1'b0;
      if (ic.en) begin
        if (ic.up) begin m_wrap = (m_bin == 8'hff); m_bin = m_bin + 8'd1; end
        else       begin m_wrap = (m_bin == 8'h00); m_bin = m_bin - 8'd1; end
      end
      m_gray = m_bin ^ (m_bin >> 1);
      tick();
      n_cmp++; if (ic.bin !== m_bin) begin n_err++; $display("FAIL rnd_bin[%0d] got %0d want %0d", k, ic.bin, m_bin); end
      n_cmp++; if (ic.gray !== m_gray) begin n_err++; $display("FAIL rnd_gray[%0d] got %h want %h", k, ic.gray, m_gray); end
      n_cmp++; if (ic.wrap !== m_wrap) begin n_err++; $display("FAIL rnd_wrap[%0d] got %b want %b", k, ic.wrap, m_wrap); end
      n_cmp++;
      if ($countones(prev_gray ^ ic.gray) != (ic.en ? 1 : 0)) begin
        n_err++; $display("FAIL rnd_hamming[%0d] got %0d want %0d", k, $countones(prev_gray ^ ic.gray), ic.en ? 1 : 0);
      end
      n_cmp++;
      if (ic.at_limit !== ((ic.up && m_bin == 8'hff) || (!ic.up && m_bin == 8'h00))) begin
        n_err++; $display("FAIL rnd_at_limit[%0d] got %b", k, ic.at_limit);
      end
    end
    ic.en = 0;
  endtask

  initial begin
    test_reset();
    test_up_sweep();
    test_down_wrap();
    test_load_priority();
    test_saturate();
    test_async_reset();
    test_width2_sweep();
    test_random_w8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
